// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: takes STORE/LOAD/COMPUTE/RMW commands, drives a
// 1-cycle-latency synchronous memory and a combinational ALU, and returns one response per command.
module cu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [2:0]        cmd_alu_op,
    input  logic              cmd_sub,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_sub,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_count
);

    localparam logic [3:0] OP_STORE   = 4'b0010;
    localparam logic [3:0] OP_LOAD    = 4'b0011;
    localparam logic [3:0] OP_COMPUTE = 4'b0100;
    localparam logic [3:0] OP_RMW     = 4'b0101;

    typedef enum logic [2:0] {IDLE, READ, CAPT, EXEC, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic                sub_q, sub_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   opr_q, opr_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            alu_op_q <= '0;
            sub_q    <= 1'b0;
            addr_q   <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
            opr_q    <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            alu_op_q <= alu_op_d;
            sub_q    <= sub_d;
            addr_q   <= addr_d;
            imm_q    <= imm_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        alu_op_d = alu_op_q;
        sub_d    = sub_q;
        addr_d   = addr_q;
        imm_d    = imm_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        err_d    = err_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    alu_op_d = cmd_alu_op;
                    sub_d    = cmd_sub;
                    addr_d   = cmd_addr;
                    imm_d    = cmd_imm;
                    err_d    = 1'b0;
                    case (cmd_opcode)
                        OP_STORE:         state_d = WRITE;
                        OP_LOAD, OP_RMW:  state_d = READ;
                        OP_COMPUTE:       state_d = EXEC;
                        default: begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                // LOAD lands straight in the accumulator; RMW parks the word in opr for EXEC.
                if (opcode_q == OP_LOAD) begin
                    acc_d   = mem_rdata;
                    state_d = DONE;
                end else begin
                    opr_d   = mem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                acc_d   = alu_result;
                state_d = (opcode_q == OP_RMW) ? WRITE : DONE;
            end
            WRITE: state_d = DONE;
            DONE: begin
                if (rsp_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The write strobe is also gated by rst so a pending write dies the instant reset rises.
    assign mem_we    = (state_q == WRITE) && !rst;
    assign mem_re    = (state_q == READ);
    assign mem_addr  = addr_q;
    assign mem_wdata = acc_q;
    assign alu_a     = (opcode_q == OP_RMW) ? opr_q : acc_q;
    assign alu_b     = imm_q;
    assign alu_op    = alu_op_q;
    assign alu_sub   = sub_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = (state_q == DONE) ? acc_q : '0;
    assign rsp_err   = (state_q == DONE) && err_q;
    assign cmd_count = count_q;

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Parametrised multi-cycle control sequencer for the simple CPU, placed between the command source, the data memory and the combinational ALU. It accepts one command per valid/ready handshake and keeps a DATA_W accumulator. It executes STORE, LOAD, COMPUTE and read-modify-write (RMW) commands against a 1-cycle-latency synchronous memory. It returns each outcome on a valid/ready response channel, with error flagging and a command counter.

## Interface
- DATA_W, 16, data/accumulator/immediate width
- ADDR_W, 16, memory address width
- CNT_W, 16, width of the completed-command counter

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_opcode  in  4  0010 STORE, 0011 LOAD, 0100 COMPUTE, 0101 RMW; all other codes illegal
- cmd_alu_op  in  3  ALU operation select
- cmd_sub  in  1  ALU subtract flag
- cmd_addr  in  ADDR_W  memory address
- cmd_imm  in  DATA_W  immediate operand
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe; mem_rdata is valid the following cycle
- mem_we  out  1  write strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  3  ALU operation select
- alu_sub  out  1  ALU subtract flag
- alu_result  in  DATA_W  combinational ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  accumulator value at completion
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE
- cmd_count  out  CNT_W  completed responses, wraps

## Operation
- States: IDLE, READ, CAPT, EXEC, WRITE, DONE.
- On the accept edge, latch opcode, alu_op, sub, addr and imm into command registers.
- Sequences by opcode:
  - STORE: IDLE→WRITE→DONE. Writes acc to mem[addr].
  - LOAD: IDLE→READ→CAPT→DONE. Sets acc = mem[addr].
  - COMPUTE: IDLE→EXEC→DONE. Sets acc = alu_result, with alu_a=acc and alu_b=imm.
  - RMW: IDLE→READ→CAPT→EXEC→WRITE→DONE. Captures the read into operand register opr. EXEC uses alu_a=opr, alu_b=imm and sets acc = alu_result. WRITE stores acc back to mem[addr].
  - Illegal opcode: IDLE→DONE with rsp_err=1. acc is unchanged.
- Per-state outputs:
  - READ: mem_re=1.
  - WRITE: mem_we=1.
  - CAPT: mem_rdata is sampled.
  - EXEC: alu_result is sampled.
- Outputs outside those states:
  - mem_re=0, mem_we=0.
  - mem_addr = latched addr.
  - mem_wdata = acc.
  - alu_a/alu_b/alu_op/alu_sub are driven from registers in every state. No output is left unassigned in any state.
- DONE:
  - rsp_valid=1, rsp_data=acc, rsp_err=error flag.
  - Hold all three until rsp_ready=1.
  - On handshake, go to IDLE and increment cmd_count mod 2^CNT_W (0xFFFF→0 at CNT_W=16).
- cmd_ready = (state==IDLE). It has no combinational dependency on cmd_valid.
- Arithmetic: ALU result truncated to DATA_W; carry/overflow ignored.
- Reset values: state IDLE; acc, opr and all command registers 0; cmd_count 0; every output 0 except cmd_ready=1.

## Timing
- Accept at edge N (count states from cycle N+1). rsp_valid rises at:
  - COMPUTE: N+2
  - STORE: N+2
  - LOAD: N+3
  - RMW: N+5
  - illegal: N+1
- With rsp_ready tied high, cmd_ready returns the cycle after DONE. No back-to-back accept; minimum 3 cycles per COMPUTE.
- mem_we and mem_re are exactly one cycle wide per command. Each RMW issues one read and one write to the same address.
- cmd inputs are ignored outside IDLE; changes during busy have no effect.
- rsp_ready low in DONE: stall indefinitely. cmd_count and acc are held.
- rst asserted mid-sequence: immediate return to reset values. mem_we drops combinationally with reset, and the pending write is lost.

## Test plan
- Reset, then COMPUTE ADD imm=0x0005 twice → rsp_data 0x0005 at N+2, then 0x000A; cmd_count=2.
- STORE addr=0x0010 with acc=0x000A, then LOAD addr=0x0010 → one mem_we pulse with wdata 0x000A; LOAD rsp_data=0x000A at N+3.
- RMW SUB addr=0x0010 (mem=0x000A), imm=0x0003 → mem[0x0010]=0x0007, rsp_data=0x0007 at N+5, single re and single we pulse.
- Opcode 0xF → rsp_err=1 at N+1, acc unchanged, cmd_count increments.
- rsp_ready held low 4 cycles in DONE → rsp_valid/rsp_data stable, cmd_ready=0; with cmd_count preset to 0xFFFF, the handshake wraps it to 0.
- rst pulsed during RMW WRITE state → mem_we=0 immediately, all outputs at reset values, cmd_ready=1 after release.
